// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - decode inputs and datapath control bundle of the multicycle controller
interface multicycle_controller_if;
  // Instruction fields and ALU flag from the datapath
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  // Datapath enables and selects from the controller
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [3:0] state;

  // Controller side
  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
  );

  // Datapath side
  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle main control FSM with ALU and immediate decoders
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Held as a plain 4-bit vector so the unused encodings 11..15 stay
  // representable and recover to FETCH through the default branch.
  logic [3:0] state_q;
  logic [3:0] state_d;

  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  // Next-state selection; op is only consulted once the IR has been loaded
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode straight from the state register
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        // OldPC + imm: branch target ready before BEQ is entered
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        mem_write  = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        branch     = 1'b1;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_update  = 1'b1;
      end
      default: begin
        // Illegal encodings: everything stays at its inactive value
      end
    endcase
  end

  // ALU decoder; only R-type (op[5]=1) with funct7b5 subtracts, addi never does
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format select depends on op only, in every state
  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Zero reaches PCWrite combinationally so a taken beq updates PC at the end of BEQ
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = imm_src;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
  } ctl_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ALU operation an arithmetic instruction should request
  function automatic logic [2:0] arith(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op == RT && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Reference control word for a given step of the instruction
  function automatic ctl_t exp_ctl(input int s, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic zero);
    ctl_t c;
    c = '0;
    c.imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    case (s)
      0:  begin c.irw = 1; c.pcw = 1; c.sb = 2; c.rs = 2; end
      1:  begin c.sa = 1; c.sb = 1; end
      2:  begin c.sa = 2; c.sb = 1; end
      3:  c.adr = 1;
      4:  begin c.rs = 1; c.rw = 1; end
      5:  begin c.adr = 1; c.mw = 1; end
      6:  begin c.sa = 2; c.alu = arith(op, f3, f7); end
      7:  begin c.sa = 2; c.sb = 1; c.alu = arith(op, f3, f7); end
      8:  c.rw = 1;
      9:  begin c.sa = 2; c.alu = 3'd1; c.pcw = zero; end
      10: begin c.sa = 1; c.sb = 2; c.pcw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t act_ctl();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc};
  endfunction

  task automatic expect_state(input int s, input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'(s));
    check({tag, "_ctl"}, 32'(act_ctl()),
          32'(exp_ctl(s, bus.op, bus.funct3, bus.funct7b5, bus.Zero)));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.Zero = 1'($urandom_range(0, 1));
    #1;
  endtask

  initial begin
    int          path[$];
    int          kind;
    logic [6:0]  bad_ops[6];
    checks = 0;
    errors = 0;
    bad_ops = '{7'h7f, 7'h37, 7'h17, 7'h67, 7'h73, 7'h00};

    reset        = 1'b1;
    bus.op       = LW;
    bus.funct3   = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;

    @(negedge clk);
    #1;
    expect_state(0, "rst_hold");
    check("rst_irwrite", 32'(bus.IRWrite), 32'd1);
    check("rst_pcwrite", 32'(bus.PCWrite), 32'd1);

    reset = 1'b0;
    expect_state(0, "rel_a");
    next_cycle(); expect_state(1, "lw_dec");
    next_cycle(); expect_state(2, "lw_adr");
    next_cycle(); expect_state(3, "lw_read");
    check("lw_read_adrsrc", 32'(bus.AdrSrc), 32'd1);

    // Asynchronous abort in the middle of MEMREAD
    #2 reset = 1'b1;
    #1;
    expect_state(0, "abort");
    @(negedge clk);
    #1;
    expect_state(0, "abort_hold");
    reset = 1'b0;
    expect_state(0, "rel_b0");
    next_cycle(); expect_state(1, "rel_b1");
    check("rel_b1_irwrite", 32'(bus.IRWrite), 32'd0);

    // Unsupported op goes straight back to FETCH with no strobes
    bus.op = BAD;
    #1;
    expect_state(1, "bad_dec");
    next_cycle(); expect_state(0, "bad_back");
    next_cycle(); expect_state(1, "bad_dec2");

    // Illegal encoding recovers to FETCH on the next edge
    force dut.state_q = 4'd13;
    #1;
    expect_state(13, "illegal");
    release dut.state_q;
    next_cycle(); expect_state(0, "illegal_exit");

    // Randomized instruction stream against the reference paths
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 6);
      bus.funct3   = 3'($urandom_range(0, 7));
      bus.funct7b5 = 1'($urandom_range(0, 1));
      case (kind)
        0: begin bus.op = LW; path = '{0, 1, 2, 3, 4}; end
        1: begin bus.op = SW; path = '{0, 1, 2, 5}; end
        2: begin bus.op = RT; path = '{0, 1, 6, 8}; end
        3: begin bus.op = IT; path = '{0, 1, 7, 8}; end
        4: begin bus.op = BQ; path = '{0, 1, 9}; end
        5: begin bus.op = JL; path = '{0, 1, 10, 8}; end
        default: begin bus.op = bad_ops[$urandom_range(0, 5)]; path = '{0, 1}; end
      endcase
      #1;
      expect_state(path[0], $sformatf("rnd%0d_k%0d_s0", n, kind));
      for (int k = 1; k < path.size(); k++) begin
        next_cycle();
        expect_state(path[k], $sformatf("rnd%0d_k%0d_s%0d", n, kind, k));
      end
      next_cycle();
    end
    expect_state(0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit of the RV32I multicycle core. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps, driving the single shared ALU's operand selects and `ALUControl`. It also drives every datapath enable: PC, IR, register file and memory writes. It decodes `op`/`funct3`/`funct7b5` from the instruction register and uses the ALU `Zero` flag to resolve `beq`.

## Interface
Parameters: none.
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — asynchronous, active-high; forces state to FETCH.
- `op`  in  7  — instruction[6:0] from the instruction register.
- `funct3`  in  3  — instruction[14:12].
- `funct7b5`  in  1  — instruction[30].
- `Zero`  in  1  — ALU result-equals-zero flag.
- `PCWrite`  out  1  — PC register enable.
- `AdrSrc`  out  1  — memory address select: 0 = PC, 1 = Result.
- `MemWrite`  out  1  — data memory write strobe.
- `IRWrite`  out  1  — instruction register and OldPC enable.
- `RegWrite`  out  1  — register file write enable.
- `ResultSrc`  out  2  — 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  — 00 = PC, 01 = OldPC, 10 = A (rs1).
- `ALUSrcB`  out  2  — 00 = B (rs2), 01 = ImmExt, 10 = constant 4.
- `ALUControl`  out  3  — 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- `ImmSrc`  out  2  — 00 = I, 01 = S, 10 = B, 11 = J.
- `state`  out  4  — current state encoding, for debug and verification.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Encodings 11–15 are illegal; from them the next state is FETCH and all write enables are 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw (0000011) or sw (0100011).
  - DECODE→EXECUTER for 0110011.
  - DECODE→EXECUTEI for 0010011.
  - DECODE→BEQ for 1100011.
  - DECODE→JAL for 1101111.
  - DECODE→FETCH for any other `op`; no writes occur.
  - MEMADR→MEMREAD if `op`=lw, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI and JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ→FETCH.
- Per-state outputs. Every signal not listed is 0.
  - FETCH: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This precomputes the branch target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & `Zero`). This is the only output with a combinational path from `Zero`.
- ALU decoder:
  - ALUOp=00 → 000.
  - ALUOp=01 → 001.
  - ALUOp=10, by `funct3`:
    - 000 → 001 if `op[5]` & `funct7b5`, else 000. `addi` never subtracts.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - any other value → 000.
- `ImmSrc` is a combinational function of `op` alone, valid in every state:
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - otherwise → 00.

## Timing
- Reset: while `reset`=1, and in the first cycle after release, state=FETCH. Outputs are the FETCH values: `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=10, `ResultSrc`=10, `ALUControl`=000, `state`=0, all others 0. Assertion mid-instruction aborts it immediately; no further writes come from the aborted instruction.
- Exactly one state per clock; there are no stalls.
- Cycles per instruction: lw 5; sw 4; R-type 4; I-ALU 4; jal 4; beq 3; unsupported op 2.
- `op` and `funct` fields are sampled only from DECODE onward. The IR holds them stable until the next FETCH.
- `Zero` is evaluated in BEQ only, in the same cycle; the PC updates at the end of BEQ when taken.

## Test plan
- Reset: assert `reset` mid-MEMREAD → `state`=0 asynchronously; after release, `state` sequence is 0,1 and `IRWrite` is high only in cycle 0.
- lw (`op`=0000011) → states 0,1,2,3,4,0. `AdrSrc`=1 in state 3; `RegWrite`=1 only in state 4 with `ResultSrc`=01.
- sw (`op`=0100011) → states 0,1,2,5,0. `MemWrite`=1 only in state 5; `ImmSrc`=01.
- R-type sub (`funct3`=000, `funct7b5`=1) → `ALUControl`=001 in state 6. The same fields with `op`=0010011 → 000 in state 7. `funct3`=010 → 101; 110 → 011; 111 → 010.
- beq with `Zero`=1 → `PCWrite`=1 in state 9 and `ALUControl`=001. With `Zero`=0 → `PCWrite`=0. In both cases the next state is 0 and the instruction takes 3 cycles.
- jal → states 0,1,10,8,0. `PCWrite`=1 in state 10 and `ImmSrc`=11. Unsupported `op`=1111111 → 1→0 with no write strobes. A forced illegal `state` value of 13 → `state`=0 on the next cycle.
